cordic_iter: RTL and testbench
==============================

# cordic_iter

Iterative, parametrised CORDIC engine built around a generalised arctangent table. It supports rotation and vectoring modes and uses a start/busy/done handshake. It computes one micro-rotation per clock and replaces the fixed 10-entry, 12-bit angle ROM with a table whose width, depth and angle resolution are set by parameters. It sits between the ADC sample path and the DAC/phase logic. It serves as the shared sin/cos, magnitude and phase unit.

## Interface
- W, 12: signed width of the x/y inputs.
- AW, 12: signed angle width, in degrees.
- ANG_FRAC, 4: fractional bits of the angle. 1 LSB = 1/16 degree, so 45.0 = 720.
- ITER, 10: number of micro-rotations, 1..16.
- c_clk  in  1  system clock, rising edge.
- c_rst_n  in  1  asynchronous reset, active low.
- i_start  in  1  request. Accepted when the state is IDLE or DONE.
- i_mode  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
- i_x, i_y  in  W  signed operands.
- i_z  in  AW  signed angle.
- o_x, o_y  out  W+2  signed results.
- o_z  out  AW  signed residual or accumulated angle.
- o_busy  out  1  high in RUN and SCALE.
- o_done  out  1  one-cycle pulse when the results become valid.
- o_range_err  out  1  the input was outside the convergence domain. Latched at accept.

## Operation
- The FSM has states IDLE, RUN, SCALE and DONE. SCALE exists only when CORDIC_GAIN_COMP_EN is defined.
- Accept (IDLE or DONE with i_start):
  - sign-extend x and y to W+2 bits;
  - load z and the mode;
  - set iter=0;
  - go to RUN.
- RUN, step i:
  - Rotation mode: d = +1 if z≥0, else −1.
  - Vectoring mode: d = +1 if y<0, else −1.
  - Update x' = x − d·(y>>>i), y' = y + d·(x>>>i), z' = z − d·atan(i).
  - Shifts are arithmetic and results are truncated; no rounding.
- After step ITER−1, go to SCALE if it is compiled in, otherwise go to DONE.
- Angle table: atan(i) = floor(atan(2^-i) in degrees · 2^ANG_FRAC). Entry 0 = 720 and entry 9 = 1 at the defaults. Entries beyond the resolution are 0.
- o_range_err is set at accept and held until the next accept:
  - rotation mode: |i_z| > 90·2^ANG_FRAC;
  - vectoring mode: i_x < 0.
  - The computation still runs; the results are then unspecified.
- Guard bits: 2 bits cover the CORDIC gain K≈1.6468. Intermediate values never wrap for full-scale inputs.
- An i_start while busy is ignored and has no side effects.
- Outputs hold their last result until the next accept loads new values.

## Timing
- Reset values: o_x=0, o_y=0, o_z=0, o_busy=0, o_done=0, o_range_err=0, state IDLE, iter=0.
- Accept edge k: o_busy=1 from k+1.
- Iteration edges run from k+1 to k+ITER.
- Without gain compensation: o_done=1 and o_busy=0 in the cycle after edge k+ITER. Latency is ITER+1 cycles from start to done.
- With gain compensation there is one extra cycle. Latency is ITER+2.
- Back-to-back operation: i_start during DONE is accepted. o_done drops and o_busy rises on the next cycle, giving no idle gap.
- Reset mid-operation (asynchronous): everything clears immediately, with no o_done.

## Configuration
- CORDIC_GAIN_COMP_EN defined:
  - SCALE multiplies x and y by 1/K = 39797/65536 (Q0.16).
  - The product is arithmetically shifted right by 16, truncated and held in W+2 bits.
  - Adds one cycle of latency.
- CORDIC_GAIN_COMP_EN not defined:
  - outputs carry the gain K;
  - the SCALE state and the multiplier are absent.

## Structure
- Package cordic_pkg contains:
  - the 16-entry atan constants at 16 fractional bits;
  - the 1/K constant;
  - the FSM state encoding;
  - the mode encodings.
- Sub-module cordic_atan_rom takes (iter index, ANG_FRAC, AW) and returns the table entry right-shifted by (16−ANG_FRAC) and truncated. It is purely combinational from the index.
- Datapath, FSM and iteration counter are in cordic_iter.

## Test plan
- Rotation, no gain compensation: x=1000, y=0, z=720 (45°) → o_x≈o_y≈1164 ±ITER LSB, |o_z|≤2, o_done exactly ITER+1 cycles after start.
- Rotation with CORDIC_GAIN_COMP_EN: same stimulus → o_x≈o_y≈707 ±ITER LSB, latency ITER+2.
- Vectoring: x=1000, y=1000, z=0 → o_z≈720 ±2, |o_y|≤ITER, o_x≈2329 (no compensation) or ≈1414 (with compensation).
- Range and handshake:
  - rotation z=1600 → o_range_err=1;
  - i_start pulsed mid-RUN → ignored, no change to the result;
  - a start in the DONE cycle is accepted back to back.
- Reset asserted at iteration 5 → all outputs 0 immediately, no o_done. After release, a new start gives a correct result.
- Table sweep with ANG_FRAC=4, ITER=16 → entries 720, 425, 224, 114, 57, 28, 14, 7, 3, 1, then 0 for every remaining entry.

Source files
------------

// File: rtl/cordic_iter_pkg.sv
// Shared constants for the iterative CORDIC engine: arctangent table in Q16 degrees,
// the 1/K gain-compensation factor, FSM state encoding and mode encoding.
package cordic_pkg;

  // floor(atan(2^-i) in degrees * 65536), i = 0..15
  localparam logic [31:0] ATAN_Q16 [16] = '{
    32'd2949120, 32'd1740967, 32'd919879, 32'd466945,
    32'd234378,  32'd117303,  32'd58666,  32'd29334,
    32'd14667,   32'd7333,    32'd3666,   32'd1833,
    32'd916,     32'd458,     32'd229,    32'd114
  };

  // 1/K in Q0.16
  localparam logic [16:0] INV_K_Q16 = 17'd39797;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_SCALE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

endpackage

// File: rtl/cordic_iter_if.sv
// Operand/result bundle of the CORDIC engine; slave is the engine side, master the requester.
interface cordic_iter_if #(
  parameter int W  = 12,
  parameter int AW = 12
);
  logic                 i_start;
  logic                 i_mode;
  logic signed [W-1:0]  i_x;
  logic signed [W-1:0]  i_y;
  logic signed [AW-1:0] i_z;
  logic signed [W+1:0]  o_x;
  logic signed [W+1:0]  o_y;
  logic signed [AW-1:0] o_z;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_range_err;

  modport slave (
    input  i_start, i_mode, i_x, i_y, i_z,
    output o_x, o_y, o_z, o_busy, o_done, o_range_err
  );

  modport master (
    output i_start, i_mode, i_x, i_y, i_z,
    input  o_x, o_y, o_z, o_busy, o_done, o_range_err
  );
endinterface

// File: rtl/cordic_iter_atan_rom.sv
// Arctangent table entry for one micro-rotation, rescaled to ANG_FRAC fractional bits.
// Purely combinational from the index; low bits beyond the resolution are truncated.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int AW       = 12,
  parameter int ANG_FRAC = 4
) (
  input  logic [3:0]           idx,
  output logic signed [AW-1:0] atan
);

  always_comb begin
    atan = AW'(ATAN_Q16[idx] >> (16 - ANG_FRAC));
  end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC (rotation/vectoring), one micro-rotation per clock; latency ITER+1, or ITER+2
// when CORDIC_GAIN_COMP_EN adds the 1/K scaling state. Starts while busy are dropped.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int W        = 12,
  parameter int AW       = 12,
  parameter int ANG_FRAC = 4,
  parameter int ITER     = 10
) (
  input  logic          c_clk,
  input  logic          c_rst_n,
  cordic_iter_if.slave  bus
);

  localparam int         XW        = W + 2;
  localparam logic [3:0] LAST      = 4'(ITER - 1);
  localparam int         RANGE_LIM = 90 << ANG_FRAC;

  state_t               state;
  logic [3:0]           iter;
  logic                 mode;
  logic signed [XW-1:0] x_q;
  logic signed [XW-1:0] y_q;
  logic signed [AW-1:0] z_q;
  logic                 range_err;

  logic signed [AW-1:0] atan_i;
  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic signed [XW-1:0] x_nx;
  logic signed [XW-1:0] y_nx;
  logic signed [AW-1:0] z_nx;
  logic signed [31:0]   z_ext;
  logic                 d_pos;
  logic                 out_of_range;

  cordic_atan_rom #(
    .AW       (AW),
    .ANG_FRAC (ANG_FRAC)
  ) u_atan_rom (
    .idx  (iter),
    .atan (atan_i)
  );

  // d = +1 drives z toward 0 in rotation, y toward 0 in vectoring
  always_comb begin
    d_pos = (mode == MODE_ROT) ? ~z_q[AW-1] : y_q[XW-1];
    x_sh  = x_q >>> iter;
    y_sh  = y_q >>> iter;
    x_nx  = d_pos ? (x_q - y_sh)   : (x_q + y_sh);
    y_nx  = d_pos ? (y_q + x_sh)   : (y_q - x_sh);
    z_nx  = d_pos ? (z_q - atan_i) : (z_q + atan_i);
  end

  always_comb begin
    z_ext        = 32'(bus.i_z);
    out_of_range = (bus.i_mode == MODE_VEC) ? bus.i_x[W-1]
                 : ((z_ext > RANGE_LIM) || (z_ext < -RANGE_LIM));
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [XW+17:0] x_prod;
  logic signed [XW+17:0] y_prod;
  logic signed [XW-1:0]  x_sc;
  logic signed [XW-1:0]  y_sc;

  always_comb begin
    x_prod = x_q * $signed({1'b0, INV_K_Q16});
    y_prod = y_q * $signed({1'b0, INV_K_Q16});
    x_sc   = XW'(x_prod >>> 16);
    y_sc   = XW'(y_prod >>> 16);
  end
`endif

  always_ff @(posedge c_clk or negedge c_rst_n) begin
    if (!c_rst_n) begin
      state     <= ST_IDLE;
      iter      <= '0;
      mode      <= MODE_ROT;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      range_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start) begin
            x_q       <= XW'(bus.i_x);
            y_q       <= XW'(bus.i_y);
            z_q       <= bus.i_z;
            mode      <= bus.i_mode;
            range_err <= out_of_range;
            iter      <= '0;
            state     <= ST_RUN;
          end else begin
            state     <= ST_IDLE;
          end
        end
        ST_RUN: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          if (iter == LAST) begin
            iter  <= '0;
`ifdef CORDIC_GAIN_COMP_EN
            state <= ST_SCALE;
`else
            state <= ST_DONE;
`endif
          end else begin
            iter  <= iter + 4'd1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_SCALE: begin
          x_q   <= x_sc;
          y_q   <= y_sc;
          state <= ST_DONE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_x         = x_q;
  assign bus.o_y         = y_q;
  assign bus.o_z         = z_q;
  assign bus.o_busy      = (state == ST_RUN) || (state == ST_SCALE);
  assign bus.o_done      = (state == ST_DONE);
  assign bus.o_range_err = range_err;

endmodule

// File: tb/tb_cordic_iter.sv
// Self-checking bench for cordic_iter: ideal real-valued model feeds a scoreboard, results checked
// within tolerance; covers latency, handshake, range flag, async reset and the angle table.
module tb_cordic_iter;
  import cordic_pkg::*;

  localparam int W        = 12;
  localparam int AW       = 12;
  localparam int ANG_FRAC = 4;
  localparam int ITER     = 10;
  localparam real PI      = 3.14159265358979;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = ITER + 2;
  localparam bit COMP = 1'b1;
`else
  localparam int LAT  = ITER + 1;
  localparam bit COMP = 1'b0;
`endif
  localparam int EXP_TAB [16] = '{720, 425, 224, 114, 57, 28, 14, 7, 3, 1, 0, 0, 0, 0, 0, 0};

  typedef struct {
    int x;
    int y;
    int z;
    int tol_xy;
    int tol_z;
    bit rerr;
    bit chk_xyz;
  } exp_t;

  logic c_clk   = 1'b0;
  logic c_rst_n = 1'b0;
  always #5 c_clk = ~c_clk;

  cordic_iter_if #(.W(W), .AW(AW)) bus ();

  cordic_iter #(
    .W        (W),
    .AW       (AW),
    .ANG_FRAC (ANG_FRAC),
    .ITER     (ITER)
  ) dut (
    .c_clk   (c_clk),
    .c_rst_n (c_rst_n),
    .bus     (bus)
  );

  logic [3:0]           rom_idx;
  logic signed [AW-1:0] rom_atan;

  cordic_atan_rom #(.AW(AW), .ANG_FRAC(16 - 12)) u_rom (
    .idx  (rom_idx),
    .atan (rom_atan)
  );

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int rnd(input real v);
    return $rtoi((v >= 0.0) ? (v + 0.5) : (v - 0.5));
  endfunction

  // Ideal CORDIC result including the accumulated gain (and 1/K when compensated)
  function automatic exp_t model(input int x, input int y, input int z, input bit mode, input int tol);
    exp_t e;
    real  k = 1.0;
    real  p = 1.0;
    real  a;
    for (int i = 0; i < ITER; i++) begin
      k = k * $sqrt(1.0 + p);
      p = p / 4.0;
    end
    if (COMP) k = k * 39797.0 / 65536.0;
    if (mode == MODE_ROT) begin
      a   = (real'(z) / real'(1 << ANG_FRAC)) * PI / 180.0;
      e.x = rnd(k * (real'(x) * $cos(a) - real'(y) * $sin(a)));
      e.y = rnd(k * (real'(y) * $cos(a) + real'(x) * $sin(a)));
      e.z = 0;
      e.rerr = (z > 90 * (1 << ANG_FRAC)) || (z < -90 * (1 << ANG_FRAC));
    end else begin
      e.x = rnd(k * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
      e.y = 0;
      e.z = rnd(real'(z) + $atan2(real'(y), real'(x)) * 180.0 / PI * real'(1 << ANG_FRAC));
      e.rerr = (x < 0);
    end
    e.tol_xy  = tol;
    e.tol_z   = 2;
    e.chk_xyz = 1'b1;
    return e;
  endfunction

  task automatic start_op(input int x, input int y, input int z, input bit mode,
                          input int tol, input bit chk, input bit push);
    exp_t e;
    @(negedge c_clk);
    bus.i_x     = W'(x);
    bus.i_y     = W'(y);
    bus.i_z     = AW'(z);
    bus.i_mode  = mode;
    bus.i_start = 1'b1;
    if (push) begin
      e = model(x, y, z, mode, tol);
      e.chk_xyz = chk;
      sb.push_back(e);
    end
    @(posedge c_clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  // Returns the number of accept-relative clock edges until o_done, or -1 on timeout
  task automatic wait_done(input int n0, output int lat);
    int n = n0;
    lat = -1;
    while (n < 200) begin
      if (bus.o_done === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge c_clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.o_x !== '0) begin errors++; $display("FAIL reset_o_x: got %0d want 0", bus.o_x); end
    checks++; if (bus.o_y !== '0) begin errors++; $display("FAIL reset_o_y: got %0d want 0", bus.o_y); end
    checks++; if (bus.o_z !== '0) begin errors++; $display("FAIL reset_o_z: got %0d want 0", bus.o_z); end
    checks++; if ({bus.o_busy, bus.o_done, bus.o_range_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {bus.o_busy, bus.o_done, bus.o_range_err});
    end
    @(negedge c_clk);
    c_rst_n = 1'b1;
  endtask

  task automatic test_rotation(input int x, input int y, input int z, input int tol);
    exp_t e;
    int   lat;
    start_op(x, y, z, MODE_ROT, tol, 1'b1, 1'b1);
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL rot_busy: got %b want 1", bus.o_busy); end
    wait_done(1, lat);
    e = sb.pop_front();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL rot_latency: got %0d want %0d", lat, LAT); end
    checks++; if (iabs(int'(bus.o_x) - e.x) > e.tol_xy) begin errors++; $display("FAIL rot_x: got %0d want %0d+-%0d", bus.o_x, e.x, e.tol_xy); end
    checks++; if (iabs(int'(bus.o_y) - e.y) > e.tol_xy) begin errors++; $display("FAIL rot_y: got %0d want %0d+-%0d", bus.o_y, e.y, e.tol_xy); end
    checks++; if (iabs(int'(bus.o_z) - e.z) > e.tol_z) begin errors++; $display("FAIL rot_z: got %0d want %0d+-%0d", bus.o_z, e.z, e.tol_z); end
    checks++; if (bus.o_range_err !== e.rerr) begin errors++; $display("FAIL rot_range_err: got %b want %b", bus.o_range_err, e.rerr); end
    @(posedge c_clk);
    #1;
    checks++; if ({bus.o_done, bus.o_busy} !== 2'b00) begin
      errors++; $display("FAIL rot_done_pulse: got done,busy=%b want 00", {bus.o_done, bus.o_busy});
    end
  endtask

  task automatic test_vectoring();
    exp_t e;
    int   lat;
    start_op(1000, 1000, 0, MODE_VEC, ITER, 1'b1, 1'b1);
    wait_done(1, lat);
    e = sb.pop_front();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL vec_latency: got %0d want %0d", lat, LAT); end
    checks++; if (iabs(int'(bus.o_x) - e.x) > e.tol_xy) begin errors++; $display("FAIL vec_x: got %0d want %0d+-%0d", bus.o_x, e.x, e.tol_xy); end
    checks++; if (iabs(int'(bus.o_y) - e.y) > e.tol_xy) begin errors++; $display("FAIL vec_y: got %0d want %0d+-%0d", bus.o_y, e.y, e.tol_xy); end
    checks++; if (iabs(int'(bus.o_z) - e.z) > e.tol_z) begin errors++; $display("FAIL vec_z: got %0d want %0d+-%0d", bus.o_z, e.z, e.tol_z); end
    checks++; if (bus.o_range_err !== 1'b0) begin errors++; $display("FAIL vec_range_err: got %b want 0", bus.o_range_err); end
  endtask

  task automatic test_range();
    exp_t e;
    int   lat;
    start_op(800, 0, 1600, MODE_ROT, ITER, 1'b0, 1'b1);
    wait_done(1, lat);
    e = sb.pop_front();
    checks++; if (bus.o_range_err !== e.rerr) begin errors++; $display("FAIL range_rot: got %b want %b", bus.o_range_err, e.rerr); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL range_rot_latency: got %0d want %0d", lat, LAT); end
    start_op(-500, 300, 0, MODE_VEC, ITER, 1'b0, 1'b1);
    wait_done(1, lat);
    e = sb.pop_front();
    checks++; if (bus.o_range_err !== e.rerr) begin errors++; $display("FAIL range_vec: got %b want %b", bus.o_range_err, e.rerr); end
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    int   lat;
    start_op(1000, 1000, 0, MODE_VEC, ITER, 1'b1, 1'b1);
    repeat (2) begin
      @(posedge c_clk);
      #1;
    end
    @(negedge c_clk);
    bus.i_x     = W'(-2000);
    bus.i_y     = W'(50);
    bus.i_z     = AW'(1700);
    bus.i_mode  = MODE_ROT;
    bus.i_start = 1'b1;
    @(posedge c_clk);
    #1;
    bus.i_start = 1'b0;
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL busy_start_busy: got %b want 1", bus.o_busy); end
    wait_done(4, lat);
    e = sb.pop_front();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", lat, LAT); end
    checks++; if (iabs(int'(bus.o_x) - e.x) > e.tol_xy) begin errors++; $display("FAIL busy_start_x: got %0d want %0d+-%0d", bus.o_x, e.x, e.tol_xy); end
    checks++; if (iabs(int'(bus.o_z) - e.z) > e.tol_z) begin errors++; $display("FAIL busy_start_z: got %0d want %0d+-%0d", bus.o_z, e.z, e.tol_z); end
    checks++; if (bus.o_range_err !== 1'b0) begin errors++; $display("FAIL busy_start_range_err: got %b want 0", bus.o_range_err); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    start_op(1000, 0, 720, MODE_ROT, ITER, 1'b1, 1'b1);
    wait_done(1, lat);
    e = sb.pop_front();
    checks++; if (iabs(int'(bus.o_y) - e.y) > e.tol_xy) begin errors++; $display("FAIL b2b_first_y: got %0d want %0d+-%0d", bus.o_y, e.y, e.tol_xy); end
    start_op(1000, 1000, 0, MODE_VEC, ITER, 1'b1, 1'b1);
    checks++; if ({bus.o_done, bus.o_busy} !== 2'b01) begin
      errors++; $display("FAIL b2b_handover: got done,busy=%b want 01", {bus.o_done, bus.o_busy});
    end
    wait_done(1, lat);
    e = sb.pop_front();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
    checks++; if (iabs(int'(bus.o_x) - e.x) > e.tol_xy) begin errors++; $display("FAIL b2b_second_x: got %0d want %0d+-%0d", bus.o_x, e.x, e.tol_xy); end
    checks++; if (iabs(int'(bus.o_z) - e.z) > e.tol_z) begin errors++; $display("FAIL b2b_second_z: got %0d want %0d+-%0d", bus.o_z, e.z, e.tol_z); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    int   seen_done = 0;
    start_op(900, 200, 1600, MODE_ROT, ITER, 1'b0, 1'b0);
    repeat (5) begin
      @(posedge c_clk);
      #1;
    end
    checks++; if ({bus.o_busy, bus.o_range_err} !== 2'b11) begin
      errors++; $display("FAIL rstmid_pre: got busy,rerr=%b want 11", {bus.o_busy, bus.o_range_err});
    end
    #2;
    c_rst_n = 1'b0;
    #1;
    checks++; if ({bus.o_x, bus.o_y} !== '0) begin errors++; $display("FAIL rstmid_xy: got x=%0d y=%0d want 0 0", bus.o_x, bus.o_y); end
    checks++; if (bus.o_z !== '0) begin errors++; $display("FAIL rstmid_z: got %0d want 0", bus.o_z); end
    checks++; if ({bus.o_busy, bus.o_done, bus.o_range_err} !== 3'b000) begin
      errors++; $display("FAIL rstmid_flags: got %b want 000", {bus.o_busy, bus.o_done, bus.o_range_err});
    end
    repeat (3) begin
      @(posedge c_clk);
      #1;
      if (bus.o_done === 1'b1) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d done cycles want 0", seen_done); end
    @(negedge c_clk);
    c_rst_n = 1'b1;
    start_op(0, 800, 360, MODE_ROT, ITER + 4, 1'b1, 1'b1);
    wait_done(1, lat);
    e = sb.pop_front();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", lat, LAT); end
    checks++; if (iabs(int'(bus.o_x) - e.x) > e.tol_xy) begin errors++; $display("FAIL rstmid_x: got %0d want %0d+-%0d", bus.o_x, e.x, e.tol_xy); end
    checks++; if (iabs(int'(bus.o_y) - e.y) > e.tol_xy) begin errors++; $display("FAIL rstmid_y: got %0d want %0d+-%0d", bus.o_y, e.y, e.tol_xy); end
  endtask

  task automatic test_atan_table();
    for (int i = 0; i < 16; i++) begin
      rom_idx = 4'(i);
      #1;
      checks++;
      if (int'(rom_atan) !== EXP_TAB[i]) begin
        errors++; $display("FAIL atan_entry_%0d: got %0d want %0d", i, rom_atan, EXP_TAB[i]);
      end
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_mode  = MODE_ROT;
    bus.i_x     = '0;
    bus.i_y     = '0;
    bus.i_z     = '0;
    rom_idx     = '0;
    test_reset();
    test_rotation(1000, 0, 720, ITER);
    test_rotation(600, 0, -480, ITER + 4);
    test_vectoring();
    test_range();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_atan_table();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
